// File: rtl/chip8_pkg.sv
// chip8_pkg: shared CHIP-8 types and constants for the memory video port and draw engine.
package chip8_pkg;

    localparam logic VIDEO_MEM_TYPE_RAM   = 1'b0;
    localparam logic VIDEO_MEM_TYPE_VRAM  = 1'b1;
    localparam int   VIDEO_MEM_TYPE_COUNT = 2;

    localparam int   VRAM_BYTES_PER_ROW   = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SPR_RD,
        ST_SPR_WAIT,
        ST_L_RD,
        ST_L_WAIT,
        ST_L_WR,
        ST_R_RD,
        ST_R_WAIT,
        ST_R_WR,
        ST_NEXT,
        ST_CLR_WR,
        ST_DONE
    } draw_state_t;

    // States that present a request on the video port while waiting for ready
    function automatic logic state_issues_req(input draw_state_t s);
        return s inside {ST_SPR_RD, ST_L_RD, ST_L_WR, ST_R_RD, ST_R_WR, ST_CLR_WR};
    endfunction

endpackage

// File: rtl/chip8_sprite_shift.sv
// chip8_sprite_shift: splits a sprite row byte across the two VRAM bytes it can straddle.
module chip8_sprite_shift (
    input  logic [7:0] i_sprite,
    input  logic [2:0] i_shift,
    output logic [7:0] o_left,
    output logic [7:0] o_right,
    output logic       o_right_en
);

    logic [15:0] w_wide;

    // Low byte of {spr,0} >> s equals (spr << (8-s)) truncated, and is 0 for s = 0
    assign w_wide     = {i_sprite, 8'h00} >> i_shift;
    assign o_left     = i_sprite >> i_shift;
    assign o_right    = w_wide[7:0];
    assign o_right_en = |o_right;

endmodule

// File: rtl/chip8_draw_engine.sv
// chip8_draw_engine: DXYN sprite draw and 00E0 clear sequencer on the memory video port.
module chip8_draw_engine
    import chip8_pkg::*;
#(
    parameter int SCREEN_W = 64,
    parameter int SCREEN_H = 32
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        draw_start_in,
    input  logic        cls_start_in,
    input  logic [7:0]  x_in,
    input  logic [7:0]  y_in,
    input  logic [3:0]  n_in,
    input  logic [11:0] i_addr_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        collision_out,
    output logic [15:0] video_addr_out,
    output logic        video_we_out,
    output logic        video_valid_out,
    output logic [15:0] video_data_out,
    output logic        video_type_out,
    output logic        video_size_out,
    input  logic        video_ready_in,
    input  logic        video_valid_in,
    input  logic [15:0] video_data_in
);

    localparam int VRAM_BYTES = SCREEN_W * SCREEN_H / 8;

    draw_state_t r_state;
    logic [5:0]  r_x0;
    logic [4:0]  r_y0;
    logic [3:0]  r_n;
    logic [11:0] r_i;
    logic [3:0]  r_row;
    logic [7:0]  r_left;
    logic [7:0]  r_right;
    logic        r_right_en;
    logic        r_coll;
    logic [15:0] r_addr;
    logic        r_we;
    logic [7:0]  r_data;
    logic        r_type;
    logic [7:0]  r_cnt;

    logic [3:0]  w_row_n;
    logic [4:0]  w_yr;
    logic [5:0]  w_yr_n;
    logic [7:0]  w_off;
    logic [7:0]  w_rd;
    logic [7:0]  w_left;
    logic [7:0]  w_right;
    logic        w_right_en;
    logic        w_right_ok;
    logic        w_unused;

    assign w_row_n    = r_row + 4'd1;
    assign w_yr       = r_y0 + {1'b0, r_row};
    assign w_yr_n     = {1'b0, r_y0} + {2'b00, w_row_n};
    assign w_off      = {w_yr, r_x0[5:3]};
    assign w_rd       = video_data_in[7:0];
    assign w_right_ok = w_right_en && (r_x0[5:3] != 3'd7);
    assign w_unused   = ^{video_data_in[15:8], x_in[7:6], y_in[7:5]};

    chip8_sprite_shift u_shift (
        .i_sprite   (w_rd),
        .i_shift    (r_x0[2:0]),
        .o_left     (w_left),
        .o_right    (w_right),
        .o_right_en (w_right_en)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= ST_IDLE;
            r_x0       <= '0;
            r_y0       <= '0;
            r_n        <= '0;
            r_i        <= '0;
            r_row      <= '0;
            r_left     <= '0;
            r_right    <= '0;
            r_right_en <= 1'b0;
            r_coll     <= 1'b0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_data     <= '0;
            r_type     <= VIDEO_MEM_TYPE_RAM;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cls_start_in) begin
                        r_state <= ST_CLR_WR;
                        r_cnt   <= '0;
                        r_addr  <= '0;
                        r_data  <= '0;
                        r_we    <= 1'b1;
                        r_type  <= VIDEO_MEM_TYPE_VRAM;
                        r_coll  <= 1'b0;
                    end else if (draw_start_in) begin
                        r_x0    <= x_in[5:0];
                        r_y0    <= y_in[4:0];
                        r_n     <= n_in;
                        r_i     <= i_addr_in;
                        r_row   <= '0;
                        r_coll  <= 1'b0;
                        r_addr  <= {4'h0, i_addr_in};
                        r_we    <= 1'b0;
                        r_type  <= VIDEO_MEM_TYPE_RAM;
                        r_state <= (n_in == 4'd0) ? ST_DONE : ST_SPR_RD;
                    end
                end
                ST_SPR_RD:
                    if (video_ready_in) r_state <= ST_SPR_WAIT;
                ST_SPR_WAIT:
                    if (video_valid_in) begin
                        r_left     <= w_left;
                        r_right    <= w_right;
                        r_right_en <= w_right_ok;
                        r_type     <= VIDEO_MEM_TYPE_VRAM;
                        r_we       <= 1'b0;
                        // Halves with no set pixels are skipped entirely
                        if (|w_left) begin
                            r_addr  <= {8'h00, w_off};
                            r_state <= ST_L_RD;
                        end else if (w_right_ok) begin
                            r_addr  <= {8'h00, w_off + 8'd1};
                            r_state <= ST_R_RD;
                        end else begin
                            r_state <= ST_NEXT;
                        end
                    end
                ST_L_RD:
                    if (video_ready_in) r_state <= ST_L_WAIT;
                ST_L_WAIT:
                    if (video_valid_in) begin
                        r_coll  <= r_coll | (|(w_rd & r_left));
                        r_data  <= w_rd ^ r_left;
                        r_we    <= 1'b1;
                        r_state <= ST_L_WR;
                    end
                ST_L_WR:
                    if (video_ready_in) begin
                        r_we    <= 1'b0;
                        r_addr  <= {8'h00, w_off + 8'd1};
                        r_state <= r_right_en ? ST_R_RD : ST_NEXT;
                    end
                ST_R_RD:
                    if (video_ready_in) r_state <= ST_R_WAIT;
                ST_R_WAIT:
                    if (video_valid_in) begin
                        r_coll  <= r_coll | (|(w_rd & r_right));
                        r_data  <= w_rd ^ r_right;
                        r_we    <= 1'b1;
                        r_state <= ST_R_WR;
                    end
                ST_R_WR:
                    if (video_ready_in) begin
                        r_we    <= 1'b0;
                        r_state <= ST_NEXT;
                    end
                ST_NEXT: begin
                    r_row   <= w_row_n;
                    r_we    <= 1'b0;
                    r_type  <= VIDEO_MEM_TYPE_RAM;
                    r_addr  <= {4'h0, r_i + {8'h00, w_row_n}};
                    r_state <= (w_row_n == r_n || w_yr_n >= 6'(SCREEN_H)) ? ST_DONE : ST_SPR_RD;
                end
                ST_CLR_WR:
                    if (video_ready_in) begin
                        if (r_cnt == 8'(VRAM_BYTES - 1)) begin
                            r_we    <= 1'b0;
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt  <= r_cnt + 8'd1;
                            r_addr <= {8'h00, r_cnt + 8'd1};
                        end
                    end
                ST_DONE:
                    r_state <= ST_IDLE;
                default:
                    r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_out        = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done_out        = (r_state == ST_DONE);
    assign collision_out   = r_coll;
    assign video_addr_out  = r_addr;
    assign video_we_out    = r_we;
    assign video_valid_out = state_issues_req(r_state) && video_ready_in;
    assign video_data_out  = {8'h00, r_data};
    assign video_type_out  = r_type;
    assign video_size_out  = 1'b0;

endmodule

// File: tb/tb_chip8_draw_engine.sv
// tb_chip8_draw_engine: randomized and directed checks of the draw engine against a pixel-level screen model.
module tb_chip8_draw_engine;
    import chip8_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        draw_start_in = 1'b0;
    logic        cls_start_in = 1'b0;
    logic [7:0]  x_in = '0;
    logic [7:0]  y_in = '0;
    logic [3:0]  n_in = '0;
    logic [11:0] i_addr_in = '0;
    logic        busy_out, done_out, collision_out;
    logic [15:0] video_addr_out;
    logic        video_we_out, video_valid_out, video_type_out, video_size_out;
    logic [15:0] video_data_out;
    logic        video_ready_in = 1'b1;
    logic        video_valid_in = 1'b0;
    logic [15:0] video_data_in = '0;

    chip8_draw_engine dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .draw_start_in(draw_start_in), .cls_start_in(cls_start_in),
        .x_in(x_in), .y_in(y_in), .n_in(n_in), .i_addr_in(i_addr_in),
        .busy_out(busy_out), .done_out(done_out), .collision_out(collision_out),
        .video_addr_out(video_addr_out), .video_we_out(video_we_out),
        .video_valid_out(video_valid_out), .video_data_out(video_data_out),
        .video_type_out(video_type_out), .video_size_out(video_size_out),
        .video_ready_in(video_ready_in), .video_valid_in(video_valid_in),
        .video_data_in(video_data_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic        typ;
        logic [7:0]  data;
    } acc_t;

    logic [7:0]  ram  [4096];
    logic [7:0]  vram [256];
    logic [7:0]  mv   [256];
    acc_t        log_q[$];
    int          exp_raddr[$];
    int          checks = 0;
    int          errors = 0;
    int          rdy_mode = 0;
    int          resp_cnt = 0;
    logic [15:0] resp_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        #2;
    endtask

    // Memory side of the video port: drive ready/response, then record the request that the next edge takes
    always @(negedge clk_in) begin
        video_valid_in = 1'b0;
        if (resp_cnt == 1) begin
            video_valid_in = 1'b1;
            video_data_in  = resp_data;
        end
        if (resp_cnt > 0) resp_cnt--;
        video_ready_in = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ~video_ready_in : ($urandom_range(0, 3) != 0);
        #1;
        chk("valid_without_ready", 32'(video_valid_out & ~video_ready_in), 32'd0);
        if (video_valid_out) begin
            log_q.push_back('{video_addr_out, video_we_out, video_type_out, video_data_out[7:0]});
            chk("req_size", 32'(video_size_out), 32'd0);
            chk("wdata_hi", 32'(video_data_out[15:8]), 32'd0);
            if (video_we_out) begin
                if (video_type_out == VIDEO_MEM_TYPE_VRAM) vram[video_addr_out[7:0]] = video_data_out[7:0];
            end else begin
                chk("one_outstanding", 32'(resp_cnt), 32'd0);
                resp_data = {8'($urandom), (video_type_out == VIDEO_MEM_TYPE_VRAM) ? vram[video_addr_out[7:0]] : ram[video_addr_out[11:0]]};
                resp_cnt  = $urandom_range(1, 3);
            end
        end
    end

    // Screen-level reference: XOR sprite pixels, clip right/bottom, count expected port accesses
    task automatic model_draw(input int x, input int y, input int n, input int i, output bit coll, output int acc);
        int x0, y0, a, c, idx, bp;
        logic [7:0] b;
        bit used[8];
        x0 = x % 64;
        y0 = y % 32;
        coll = 1'b0;
        acc = 0;
        exp_raddr.delete();
        for (int r = 0; r < n; r++) begin
            if (y0 + r >= 32) break;
            a = (i + r) % 4096;
            exp_raddr.push_back(a);
            acc++;
            b = ram[a];
            foreach (used[k]) used[k] = 1'b0;
            for (int p = 0; p < 8; p++) begin
                c = x0 + p;
                if (b[7-p] && c < 64) begin
                    idx = (y0 + r) * 8 + c / 8;
                    bp = 7 - c % 8;
                    if (mv[idx][bp]) coll = 1'b1;
                    mv[idx][bp] = ~mv[idx][bp];
                    used[c/8] = 1'b1;
                end
            end
            foreach (used[k]) if (used[k]) acc += 2;
        end
    endtask

    function automatic int vram_diff();
        int d = 0;
        foreach (vram[j]) if (vram[j] !== mv[j]) d++;
        return d;
    endfunction

    function automatic int ram_reads();
        int c = 0;
        foreach (log_q[j]) if (!log_q[j].we && log_q[j].typ == VIDEO_MEM_TYPE_RAM) c++;
        return c;
    endfunction

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (done_out) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_done_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic run_draw(input string tag, input int x, input int y, input int n, input int i, output bit coll);
        bit ec;
        int ea, bad, k;
        model_draw(x, y, n, i, ec, ea);
        log_q.delete();
        x_in = 8'(x);
        y_in = 8'(y);
        n_in = 4'(n);
        i_addr_in = 12'(i);
        draw_start_in = 1'b1;
        tick();
        draw_start_in = 1'b0;
        if (n == 0) chk({tag, "_n0_done_next"}, 32'(done_out), 32'd1);
        else chk({tag, "_busy"}, 32'(busy_out), 32'd1);
        wait_done(tag);
        coll = collision_out;
        chk({tag, "_coll"}, 32'(collision_out), 32'(ec));
        chk({tag, "_busy_at_done"}, 32'(busy_out), 32'd0);
        tick();
        chk({tag, "_done_one_cycle"}, 32'(done_out), 32'd0);
        chk({tag, "_coll_hold"}, 32'(collision_out), 32'(ec));
        chk({tag, "_accesses"}, 32'(log_q.size()), 32'(ea));
        bad = 0;
        k = 0;
        foreach (log_q[j]) if (!log_q[j].we && log_q[j].typ == VIDEO_MEM_TYPE_RAM) begin
            if (k >= exp_raddr.size() || int'(log_q[j].addr) != exp_raddr[k]) bad++;
            k++;
        end
        if (k != exp_raddr.size()) bad++;
        chk({tag, "_ram_addrs"}, 32'(bad), 32'd0);
        chk({tag, "_vram"}, 32'(vram_diff()), 32'd0);
    endtask

    task automatic run_clear(input string tag, input bit both, input bit inject);
        int bad;
        log_q.delete();
        cls_start_in = 1'b1;
        draw_start_in = both;
        n_in = 4'd3;
        i_addr_in = 12'h200;
        tick();
        cls_start_in = 1'b0;
        draw_start_in = 1'b0;
        chk({tag, "_busy"}, 32'(busy_out), 32'd1);
        if (inject) begin
            repeat (40) tick();
            draw_start_in = 1'b1;
            n_in = 4'd2;
            tick();
            draw_start_in = 1'b0;
            chk({tag, "_busy_after_ignored"}, 32'(busy_out), 32'd1);
        end
        wait_done(tag);
        chk({tag, "_coll"}, 32'(collision_out), 32'd0);
        bad = (log_q.size() == 256) ? 0 : 1;
        foreach (log_q[j])
            if (log_q[j].addr !== 16'(j) || log_q[j].we !== 1'b1 || log_q[j].typ !== VIDEO_MEM_TYPE_VRAM || log_q[j].data !== 8'h00) bad++;
        chk({tag, "_order"}, 32'(bad), 32'd0);
        foreach (mv[j]) mv[j] = 8'h00;
        chk({tag, "_vram"}, 32'(vram_diff()), 32'd0);
        repeat (5) tick();
        chk({tag, "_quiet"}, 32'(log_q.size()), 32'd256);
        chk({tag, "_idle"}, 32'(busy_out), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit c;
        int nlog;
        bit hit;
        foreach (ram[j]) ram[j] = 8'($urandom);
        foreach (vram[j]) begin
            vram[j] = 8'h00;
            mv[j] = 8'h00;
        end
        #1 rst_in = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        chk("rst_coll", 32'(collision_out), 32'd0);
        chk("rst_valid", 32'(video_valid_out), 32'd0);
        chk("rst_we", 32'(video_we_out), 32'd0);
        chk("rst_addr", 32'(video_addr_out), 32'd0);
        chk("rst_data", 32'(video_data_out), 32'd0);
        chk("rst_type", 32'(video_type_out), 32'(VIDEO_MEM_TYPE_RAM));
        chk("rst_size", 32'(video_size_out), 32'd0);
        rst_in = 1'b0;
        tick();

        ram[12'h200] = 8'hF0;
        run_draw("aligned", 0, 0, 1, 'h200, c);
        chk("aligned_vram0", 32'(vram[0]), 32'h0F0);
        chk("aligned_coll0", 32'(c), 32'd0);
        if (log_q.size() == 3) begin
            chk("aligned_log0", {log_q[0].addr, 7'd0, log_q[0].we, 7'd0, log_q[0].typ}, {16'h0200, 16'h0000});
            chk("aligned_log1", {log_q[1].addr, 7'd0, log_q[1].we, 7'd0, log_q[1].typ}, {16'h0000, 16'h0001});
            chk("aligned_log2", {log_q[2].addr, log_q[2].data, 7'd0, log_q[2].we}, {16'h0000, 16'hF001});
        end
        run_draw("again", 0, 0, 1, 'h200, c);
        chk("again_vram0", 32'(vram[0]), 32'h000);
        chk("again_coll1", 32'(c), 32'd1);

        ram[12'h210] = 8'hFF;
        run_draw("unaligned", 3, 2, 1, 'h210, c);
        chk("unaligned_vram16", 32'(vram[16]), 32'h01F);
        chk("unaligned_vram17", 32'(vram[17]), 32'h0E0);

        ram[12'h220] = 8'hFF;
        run_draw("rclip", 60, 0, 1, 'h220, c);
        chk("rclip_vram7", 32'(vram[7]), 32'h00F);
        chk("rclip_vram8", 32'(vram[8]), 32'h000);

        rdy_mode = 2;
        run_draw("bclip", 70, 30, 5, 'h230, c);
        chk("bclip_ram_reads", 32'(ram_reads()), 32'd2);

        run_draw("iwrap", 5, 10, 2, 'hFFF, c);
        run_draw("n0", 12, 7, 0, 'h400, c);

        for (int t = 0; t < 24; t++) begin
            rdy_mode = $urandom_range(0, 2);
            run_draw("rand", $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 4095), c);
        end

        rdy_mode = 1;
        run_clear("cls_toggle", 1'b0, 1'b1);

        rdy_mode = 2;
        run_draw("pre_both", 9, 3, 6, 'h500, c);
        run_clear("cls_wins", 1'b1, 1'b0);

        rdy_mode = 0;
        ram[12'h300] = 8'hA5;
        ram[12'h301] = 8'h3C;
        ram[12'h302] = 8'hFF;
        log_q.delete();
        x_in = 8'd8;
        y_in = 8'd4;
        n_in = 4'd3;
        i_addr_in = 12'h300;
        draw_start_in = 1'b1;
        tick();
        draw_start_in = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (ram_reads() == 2) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        chk("rst_mid_reach_row1", 32'(hit), 32'd1);
        rst_in = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy_out), 32'd0);
        chk("rst_mid_done", 32'(done_out), 32'd0);
        chk("rst_mid_valid", 32'(video_valid_out), 32'd0);
        chk("rst_mid_we", 32'(video_we_out), 32'd0);
        chk("rst_mid_addr", 32'(video_addr_out), 32'd0);
        chk("rst_mid_type", 32'(video_type_out), 32'(VIDEO_MEM_TYPE_RAM));
        tick();
        rst_in = 1'b0;
        nlog = log_q.size();
        repeat (6) tick();
        chk("rst_stale_busy", 32'(busy_out), 32'd0);
        chk("rst_stale_done", 32'(done_out), 32'd0);
        chk("rst_stale_no_traffic", 32'(log_q.size()), 32'(nlog));
        foreach (vram[j]) mv[j] = vram[j];

        rdy_mode = 2;
        run_draw("post_reset", 20, 12, 4, 'h300, c);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chip8_draw_engine.md
Name: chip8_draw_engine

Overview:
- Executes CHIP-8 display operations (DXYN sprite draw, 00E0 clear) for the processor.
- Sequences byte accesses over the memory block's video port: sprite fetch from RAM, VRAM read-modify-write, and VF collision reporting.
- Sits between the processor FSM (start/done) and the video request/response channel of chip8_memory.

Parameters:
- SCREEN_W, 64, pixel columns (8 bytes per row, MSB = leftmost pixel)
- SCREEN_H, 32, pixel rows; VRAM bytes = SCREEN_W*SCREEN_H/8 = 256

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- draw_start_in  input  1  pulse: begin DXYN with the operands below
- cls_start_in  input  1  pulse: begin screen clear
- x_in  input  8  VX value; only [5:0] used (mod 64)
- y_in  input  8  VY value; only [4:0] used (mod 32)
- n_in  input  4  sprite height in rows
- i_addr_in  input  12  sprite base address in RAM (I register)
- busy_out  output  1  operation in progress
- done_out  output  1  one-cycle pulse when the operation completes
- collision_out  output  1  VF result; valid while done_out is high, held until the next start
- video_addr_out  output  16  request address (RAM byte address or VRAM byte offset)
- video_we_out  output  1  request is a write
- video_valid_out  output  1  request strobe, one cycle
- video_data_out  output  16  write byte in [7:0]; [15:8] = 0
- video_type_out  output  1  VIDEO_MEM_TYPE_RAM or VIDEO_MEM_TYPE_VRAM
- video_size_out  output  1  always 0 (single byte)
- video_ready_in  input  1  memory can accept a video request this cycle
- video_valid_in  input  1  read data valid
- video_data_in  input  16  read data; byte in [7:0]

Behaviour:
- Reset (asynchronous): state IDLE.
  - Outputs busy/done/collision/video_valid/video_we = 0; addr/data = 0; type = RAM; size = 0.
- Request rule:
  - Drive video_valid_out for exactly one cycle, and only in a cycle where video_ready_in = 1.
  - Address, type, we and data are stable in that cycle.
  - Reads: wait for video_valid_in and capture video_data_in[7:0]. Only one read is outstanding at a time.
  - Writes: no response; continue when video_ready_in returns high.
- Start handling:
  - Starts are accepted only in IDLE. Starts while busy are ignored.
  - Simultaneous draw_start_in and cls_start_in: clear wins.
  - busy_out rises the cycle after the accepted start.
- Draw FSM: IDLE -> SPR_RD -> SPR_WAIT -> L_RD -> L_WAIT -> L_WR -> R_RD -> R_WAIT -> R_WR -> NEXT -> DONE -> IDLE.
  - At start, latch x0 = x_in[5:0], y0 = y_in[4:0], n, I; clear collision; row = 0.
  - SPR_RD: RAM read at (I + row) mod 4096 (12-bit wrap).
  - Shift: s = x0[2:0]. left = spr >> s, at VRAM offset (y0+row)*8 + x0[5:3]. right = (spr << (8-s))[7:0], at the same offset + 1.
  - L_RD/L_WAIT/L_WR: read the VRAM byte, collision |= |(old & left), write old ^ left.
  - The right byte is processed the same way only if s != 0 and x0[5:3] != 7 (right-edge clip, no wrap).
  - Any byte whose shifted sprite part is 0 is skipped (no read, no write).
  - NEXT: row++. Go to DONE if row == n or y0 + row >= 32 (bottom clip, no wrap). Otherwise go to SPR_RD.
  - n = 0: go directly to DONE with collision 0 and no memory accesses.
- Clear FSM: CLR_WR writes 0 to VRAM offsets 0..255 in ascending order, one write per ready cycle.
  - An 8-bit counter runs until it wraps from 255, then DONE. collision_out = 0.
- DONE: done_out = 1 and busy_out = 0 for one cycle, then IDLE. collision_out holds.
- Reset mid-operation:
  - Return immediately to IDLE and drop any outstanding read.
  - A stale video_valid_in arriving in IDLE is ignored.
- Arithmetic: VRAM offsets are 8 bits. y0+row is computed 6 bits wide for the clip compare.

Decomposition:
- Shared chip8 package:
  - VIDEO_MEM_TYPE_RAM, VIDEO_MEM_TYPE_VRAM, VIDEO_MEM_TYPE_COUNT (already present).
  - New draw_state_t enum.
  - VRAM_BYTES_PER_ROW = 8.
- One combinational sub-module, chip8_sprite_shift: inputs sprite byte and s; outputs left, right, right_en.

Test Plan:
- Draw 0-pixel collision, aligned: RAM[0x200] = 0xF0, x = 0, y = 0, n = 1, VRAM zero -> one RAM read, VRAM[0] read then written 0xF0, no right access, done with collision = 0.
- Same draw again -> VRAM[0] = 0x00, collision = 1.
- Unaligned: sprite 0xFF, x = 3, y = 2 -> VRAM[16] ^= 0x1F, VRAM[17] ^= 0xE0.
- Right clip: sprite 0xFF, x = 60 -> only VRAM[7] ^= 0x0F, no access to offset 8.
- Bottom clip and wrap: y = 30, n = 5, x = 70 (treated as 6) -> two rows drawn at rows 30-31, three rows skipped.
- Address wrap: I = 0xFFF, n = 2 -> sprite reads from 0xFFF then 0x000.
- Clear plus back-pressure: cls with video_ready_in toggling every other cycle -> 256 zero writes in order, valid only when ready, done pulse after offset 255.
- Ignored start and n = 0: draw_start during clear is ignored; reset at row 1 of a draw gives idle outputs and ignores a stale video_valid_in; n = 0 gives done next state with zero memory traffic.
